matrix_fb_arbiter: RTL and testbench

- Owns the single-port SPRAM frame buffer behind the LED matrix and shares it between two requesters: the matrix scan engine's pixel reader (16-bit word reads) and the CPU Wishbone bus (8-bit byte reads/writes).
- Replaces the ad-hoc mem_busy mux with an explicit grant state machine, fixed latencies and a starvation guard.
- Sits between the Wishbone interconnect, the matrix scan engine and one SB_SPRAM256KA instance.

---
 rtl/matrix_fb_arbiter.sv | 141 ++++++++++++++
 tb/tb_matrix_fb_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_fb_arbiter.sv
// Frame-buffer arbiter: shares one SPRAM between the LED scan reader and Wishbone byte accesses.
// Define MATRIX_FB_ARB_STATS_EN to add the wb_stall_count_o Wishbone stall counter.
module matrix_fb_arbiter #(
    parameter int ADDRESS_WIDTH    = 16,
    parameter int MEM_ADDR_WIDTH   = 14,
    parameter int BASE_MEM_ADDRESS = 'h8000,
    parameter int STARVE_LIMIT     = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [ADDRESS_WIDTH-1:0]  adr_i,
    input  logic [7:0]                dat_i,
    output logic [7:0]                dat_o,
    input  logic                      we_i,
    input  logic                      sel_i,
    input  logic                      stb_i,
    input  logic                      cyc_i,
    output logic                      ack_o,
    input  logic                      disp_req_i,
    input  logic [MEM_ADDR_WIDTH-1:0] disp_addr_i,
    output logic                      disp_ack_o,
    output logic [15:0]               disp_data_o,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
    output logic [15:0]               mem_data_o,
    output logic [3:0]                mem_maskwren_o,
    output logic                      mem_wren_o,
    input  logic [15:0]               mem_data_i
`ifdef MATRIX_FB_ARB_STATS_EN
    ,
    output logic [15:0]               wb_stall_count_o
`endif
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [ADDRESS_WIDTH-1:0] WIN_MASK = ADDRESS_WIDTH'((1 << (MEM_ADDR_WIDTH + 1)) - 1);
    localparam logic [ADDRESS_WIDTH-1:0] WIN_BASE = ADDRESS_WIDTH'(BASE_MEM_ADDRESS);
    localparam logic [SW-1:0]            STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [SW-1:0]       r_starve;
    logic                r_gnt_wb;
    logic                r_is_write;
    logic                r_lane;
    logic                r_cyc_ok;
    logic                w_hit;
    logic                w_starved;
    logic                w_grant_wb;
    logic                w_grant_disp;

    assign w_hit        = cyc_i & stb_i & ((adr_i & ~WIN_MASK) == WIN_BASE);
    assign w_starved    = w_hit & (r_starve == STARVE_MAX);
    assign w_grant_disp = (r_state == IDLE) & disp_req_i & ~w_starved;
    assign w_grant_wb   = (r_state == IDLE) & w_hit & ~w_grant_disp;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_grant_disp | w_grant_wb) w_state_next = ISSUE;
            ISSUE:   w_state_next = r_is_write ? DONE : WAIT;
            WAIT:    w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_starve       <= '0;
            r_gnt_wb       <= 1'b0;
            r_is_write     <= 1'b0;
            r_lane         <= 1'b0;
            r_cyc_ok       <= 1'b0;
            mem_addr_o     <= '0;
            mem_data_o     <= '0;
            mem_maskwren_o <= '0;
            mem_wren_o     <= 1'b0;
            dat_o          <= '0;
            disp_data_o    <= '0;
            ack_o          <= 1'b0;
            disp_ack_o     <= 1'b0;
        end else begin
            mem_wren_o     <= 1'b0;
            mem_maskwren_o <= '0;
            if (w_grant_disp | w_grant_wb) begin
                r_gnt_wb   <= w_grant_wb;
                r_is_write <= w_grant_wb & we_i;
                r_lane     <= adr_i[0];
                r_cyc_ok   <= 1'b1;
                mem_addr_o <= w_grant_wb ? adr_i[MEM_ADDR_WIDTH:1] : disp_addr_i;
                mem_data_o <= {dat_i, dat_i};
                if (w_grant_wb & we_i & sel_i) begin
                    mem_wren_o     <= 1'b1;
                    mem_maskwren_o <= adr_i[0] ? 4'b1100 : 4'b0011;
                end
            end else if (r_state != IDLE && !cyc_i) begin
                // Master abandoned the cycle: finish the memory op but never ack it.
                r_cyc_ok <= 1'b0;
            end

            if (r_state == IDLE) begin
                if (w_grant_wb || !w_hit)
                    r_starve <= '0;
                else if (w_grant_disp && r_starve != STARVE_MAX)
                    r_starve <= r_starve + 1'b1;
            end

            if (r_state == WAIT) begin
                if (r_gnt_wb) dat_o       <= r_lane ? mem_data_i[15:8] : mem_data_i[7:0];
                else          disp_data_o <= mem_data_i;
            end

            ack_o      <= (w_state_next == DONE) & r_gnt_wb & r_cyc_ok & cyc_i;
            disp_ack_o <= (w_state_next == DONE) & ~r_gnt_wb;
        end
    end

`ifdef MATRIX_FB_ARB_STATS_EN
    logic r_wb_stall_cnt_unused;
    logic [15:0] r_wb_stall_count;
    assign r_wb_stall_cnt_unused = 1'b0;
    assign wb_stall_count_o = r_wb_stall_count;

    // A hit already being served by its own transaction is not a stall.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            r_wb_stall_count <= '0;
        else if (w_hit && !w_grant_wb && !(r_state != IDLE && r_gnt_wb)
                 && r_wb_stall_count != 16'hFFFF)
            r_wb_stall_count <= r_wb_stall_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_matrix_fb_arbiter.sv
// Directed bench for matrix_fb_arbiter with a behavioural SPRAM model (nibble write mask, 1-cycle read).
module tb_matrix_fb_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [15:0] adr_i = '0;
    logic [7:0]  dat_i = '0;
    logic [7:0]  dat_o;
    logic        we_i = 1'b0, sel_i = 1'b0, stb_i = 1'b0, cyc_i = 1'b0;
    logic        ack_o;
    logic        disp_req_i = 1'b0;
    logic [13:0] disp_addr_i = '0;
    logic        disp_ack_o;
    logic [15:0] disp_data_o;
    logic [13:0] mem_addr_o;
    logic [15:0] mem_data_o;
    logic [3:0]  mem_maskwren_o;
    logic        mem_wren_o;
    logic [15:0] mem_data_i = '0;
`ifdef MATRIX_FB_ARB_STATS_EN
    logic [15:0] wb_stall_count_o;
`endif

    int n_compared = 0;
    int n_mismatched = 0;
    logic tb_clear = 1'b1;
    logic [15:0] mem [0:16383];

    always #5 clk_i = ~clk_i;

    matrix_fb_arbiter dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o),
        .we_i(we_i), .sel_i(sel_i), .stb_i(stb_i), .cyc_i(cyc_i), .ack_o(ack_o),
        .disp_req_i(disp_req_i), .disp_addr_i(disp_addr_i), .disp_ack_o(disp_ack_o),
        .disp_data_o(disp_data_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_maskwren_o(mem_maskwren_o), .mem_wren_o(mem_wren_o), .mem_data_i(mem_data_i)
`ifdef MATRIX_FB_ARB_STATS_EN
        , .wb_stall_count_o(wb_stall_count_o)
`endif
    );

    always @(posedge clk_i) begin
        logic [15:0] w;
        if (tb_clear) begin
            for (int i = 0; i < 16384; i++) mem[i] <= 16'h0000;
        end else begin
            mem_data_i <= mem[mem_addr_o];
            if (mem_wren_o) begin
                w = mem[mem_addr_o];
                for (int k = 0; k < 4; k++)
                    if (mem_maskwren_o[k]) w[k*4 +: 4] = mem_data_o[k*4 +: 4];
                mem[mem_addr_o] <= w;
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic wb_access(input string tag, input logic [15:0] adr, input logic we,
                             input logic sel, input logic [7:0] wdat, input int exp_lat,
                             input logic exp_wren, input logic [13:0] exp_addr,
                             input logic [3:0] exp_mask);
        int lat;
        logic wren_seen;
        logic [13:0] addr_seen;
        logic [3:0] mask_seen;
        lat = 0; wren_seen = 1'b0; addr_seen = '0; mask_seen = '0;
        adr_i = adr; we_i = we; sel_i = sel; dat_i = wdat; cyc_i = 1'b1; stb_i = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk_i); #1;
            if (n == 1) begin
                wren_seen = mem_wren_o; addr_seen = mem_addr_o; mask_seen = mem_maskwren_o;
            end
            if (ack_o) begin lat = n; break; end
        end
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        check_val({tag, " latency"}, lat, exp_lat);
        check_val({tag, " wren"}, {31'd0, wren_seen}, {31'd0, exp_wren});
        check_val({tag, " addr"}, {18'd0, addr_seen}, {18'd0, exp_addr});
        check_val({tag, " mask"}, {28'd0, mask_seen}, {28'd0, exp_mask});
        @(posedge clk_i); #1;
        check_val({tag, " ack pulse"}, {31'd0, ack_o}, 32'd0);
    endtask

    task automatic disp_read(input string tag, input logic [13:0] addr, input logic [15:0] exp_data);
        int lat;
        logic wr;
        lat = 0; wr = 1'b0;
        disp_addr_i = addr; disp_req_i = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk_i); #1;
            if (mem_wren_o) wr = 1'b1;
            if (disp_ack_o) begin lat = n; break; end
        end
        disp_req_i = 1'b0;
        check_val({tag, " latency"}, lat, 3);
        check_val({tag, " data"}, {16'd0, disp_data_o}, {16'd0, exp_data});
        check_val({tag, " no wren"}, {31'd0, wr}, 32'd0);
        @(posedge clk_i); #1;
        check_val({tag, " ack pulse"}, {31'd0, disp_ack_o}, 32'd0);
    endtask

    initial begin
        int dacks;
        logic got, resumed, any_ack;

        repeat (3) @(posedge clk_i);
        #1;
        tb_clear = 1'b0;
        check_val("rst ack", {31'd0, ack_o}, 32'd0);
        check_val("rst disp_ack", {31'd0, disp_ack_o}, 32'd0);
        check_val("rst wren", {31'd0, mem_wren_o}, 32'd0);
        check_val("rst outputs", {mem_addr_o, mem_maskwren_o, dat_o}, 32'd0);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        wb_access("wr 8003", 16'h8003, 1'b1, 1'b1, 8'hA5, 2, 1'b1, 14'd1, 4'b1100);
        wb_access("rd 8003", 16'h8003, 1'b0, 1'b1, 8'h00, 3, 1'b0, 14'd1, 4'b0000);
        check_val("rd 8003 dat", {24'd0, dat_o}, 32'h0000_00A5);

        wb_access("wr 8000", 16'h8000, 1'b1, 1'b1, 8'h3C, 2, 1'b1, 14'd0, 4'b0011);
        wb_access("wr 8001", 16'h8001, 1'b1, 1'b1, 8'hC3, 2, 1'b1, 14'd0, 4'b1100);
        wb_access("wr sel0", 16'h8000, 1'b1, 1'b0, 8'h77, 2, 1'b0, 14'd0, 4'b0000);
        disp_read("disp w0", 14'h0000, 16'hC33C);

        wb_access("wr 8020", 16'h8020, 1'b1, 1'b1, 8'h34, 2, 1'b1, 14'h10, 4'b0011);
        wb_access("wr 8021", 16'h8021, 1'b1, 1'b1, 8'h12, 2, 1'b1, 14'h10, 4'b1100);
        disp_read("disp w10", 14'h0010, 16'h1234);

        // Display held continuously while a Wishbone read waits.
        disp_addr_i = 14'h0010; disp_req_i = 1'b1;
        adr_i = 16'h8003; we_i = 1'b0; sel_i = 1'b1; cyc_i = 1'b1; stb_i = 1'b1;
        dacks = 0; got = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk_i); #1;
            if (disp_ack_o) dacks++;
            if (ack_o) begin got = 1'b1; break; end
        end
        cyc_i = 1'b0; stb_i = 1'b0;
        check_val("starve wb ack", {31'd0, got}, 32'd1);
        check_val("starve disp acks", dacks, 4);
        check_val("starve wb dat", {24'd0, dat_o}, 32'h0000_00A5);
`ifdef MATRIX_FB_ARB_STATS_EN
        check_val("stall count", {16'd0, wb_stall_count_o}, 32'd16);
`endif
        resumed = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk_i); #1;
            if (disp_ack_o) begin resumed = 1'b1; break; end
        end
        disp_req_i = 1'b0;
        check_val("disp resumed", {31'd0, resumed}, 32'd1);
        check_val("disp resumed data", {16'd0, disp_data_o}, 32'h0000_1234);
        @(posedge clk_i); #1;

        // Reset while a write sits in ISSUE.
        adr_i = 16'h8000; we_i = 1'b1; sel_i = 1'b1; dat_i = 8'hFF; cyc_i = 1'b1; stb_i = 1'b1;
        @(posedge clk_i); #1;
        check_val("issue wren", {31'd0, mem_wren_o}, 32'd1);
        #2 rst_ni = 1'b0;
        #1;
        check_val("async rst wren", {31'd0, mem_wren_o}, 32'd0);
        check_val("async rst outs", {mem_addr_o, mem_maskwren_o, dat_o}, 32'd0);
        check_val("async rst disp", {disp_data_o, 14'd0, ack_o, disp_ack_o}, 32'd0);
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        any_ack = 1'b0;
        repeat (5) begin
            @(posedge clk_i); #1;
            if (ack_o || disp_ack_o) any_ack = 1'b1;
        end
        check_val("post rst no ack", {31'd0, any_ack}, 32'd0);
        disp_read("post rst w0", 14'h0000, 16'hC33C);
`ifdef MATRIX_FB_ARB_STATS_EN
        check_val("stall cleared", {16'd0, wb_stall_count_o}, 32'd0);
`endif

        // Out-of-window addresses must be ignored.
        any_ack = 1'b0;
        adr_i = 16'h7FFF; cyc_i = 1'b1; stb_i = 1'b1;
        repeat (6) begin
            @(posedge clk_i); #1;
            if (ack_o || mem_wren_o) any_ack = 1'b1;
        end
        adr_i = 16'h0000; we_i = 1'b1;
        repeat (6) begin
            @(posedge clk_i); #1;
            if (ack_o || mem_wren_o) any_ack = 1'b1;
        end
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        check_val("non-hit ignored", {31'd0, any_ack}, 32'd0);
`ifdef MATRIX_FB_ARB_STATS_EN
        check_val("stall non-hit", {16'd0, wb_stall_count_o}, 32'd0);
`endif

        // cyc dropped after grant: write lands, no ack.
        adr_i = 16'h8041; we_i = 1'b1; sel_i = 1'b1; dat_i = 8'h5A; cyc_i = 1'b1; stb_i = 1'b1;
        @(posedge clk_i); #1;
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        any_ack = 1'b0;
        repeat (5) begin
            @(posedge clk_i); #1;
            if (ack_o) any_ack = 1'b1;
        end
        check_val("cyc drop no ack", {31'd0, any_ack}, 32'd0);
        disp_read("cyc drop landed", 14'h0020, 16'h5A00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: sim time exceeded limit");
        $fatal(1, "timeout");
    end

endmodule
